// File: rtl/mips_abb_pkg.sv
// Shared pipeline constants and types for the MIPS pipeline control blocks.
package mips_abb_pkg;

    // Pipeline stage indices
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    // Width of one stall-source stage tag inside the packed SRC_STAGE vector
    localparam int TAG_W = 3;

    // Deferred-flush state machine
    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } flush_fsm_e;

endpackage

// File: rtl/stall_sat_cnt.sv
// Saturating up-counter with synchronous clear; one instance per stall source.
module stall_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Clear wins over increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: merges stage-tagged stall requests and a
// flush request into per-stage stall/bubble/flush vectors, defers flushes that
// are blocked by downstream stalls, counts stalled cycles per source and
// flags a pipeline stuck in stall.
//
// state  | meaning
// F_IDLE | no flush pending; unblocked flushes go straight out
// F_WAIT | flush latched, waiting for blocking stall requests to clear
module pipe_hazard_ctrl
    import mips_abb_pkg::*;
#(
    parameter int                      NSTAGE    = 5,
    parameter int                      NSRC      = 3,
    parameter logic [NSRC*TAG_W-1:0]   SRC_STAGE = {3'd3, 3'd1, 3'd0},
    parameter int                      CNT_W     = 32,
    parameter int                      WDOG_CYC  = 1023,
    localparam int                     SW        = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic                    cpu_clk,
    input  logic                    cpu_rst_n,
    input  logic [NSRC-1:0]         stall_req,
    input  logic                    flush_req,
    input  logic [SW-1:0]           flush_stg,
    input  logic                    cnt_clr,
    output logic [NSTAGE-1:0]       stall,
    output logic [NSTAGE-1:0]       bubble,
    output logic [NSTAGE-1:0]       flush,
    output logic                    flush_busy,
    output logic [NSRC*CNT_W-1:0]   stall_cnt,
    output logic                    wdog_err
);

    localparam int WD_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((WDOG_CYC > 0) ? WDOG_CYC - 1 : 0);

    flush_fsm_e          state, state_nxt;
    logic [SW-1:0]       pend, pend_nxt;
    logic [SW-1:0]       fs;
    logic [SW-1:0]       eff_f;
    logic                req_v;
    logic                blk_new, blk_pend;
    logic                accept, release_now, flush_act;
    logic                s_any;
    int                  s_max;
    logic [NSTAGE-1:0]   stall_int, bubble_int, flush_int;
    logic [WD_W-1:0]     wd_cnt;

    // Out-of-range flush stages are treated as a flush from the last stage;
    // a flush from stage 0 kills nothing and is ignored entirely.
    always_comb begin
        fs    = (int'(flush_stg) >= NSTAGE) ? SW'(NSTAGE - 1) : flush_stg;
        req_v = flush_req && (fs != '0);
    end

    // A flush is blocked while any source at or below it in the pipe still stalls.
    always_comb begin
        blk_new  = 1'b0;
        blk_pend = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (stall_req[i]) begin
                if (int'(SRC_STAGE[i*TAG_W +: TAG_W]) >= int'(fs))   blk_new  = 1'b1;
                if (int'(SRC_STAGE[i*TAG_W +: TAG_W]) >= int'(pend)) blk_pend = 1'b1;
            end
        end
    end

    // Flush FSM next-state and effective flush stage.
    always_comb begin
        state_nxt   = state;
        pend_nxt    = pend;
        accept      = 1'b0;
        release_now = 1'b0;
        eff_f       = fs;
        case (state)
            F_IDLE: begin
                if (req_v) begin
                    if (!blk_new) begin
                        accept = 1'b1;
                    end else begin
                        state_nxt = F_WAIT;
                        pend_nxt  = fs;
                    end
                end
            end
            F_WAIT: begin
                eff_f = pend;
                if (!blk_pend) begin
                    release_now = 1'b1;
                    state_nxt   = F_IDLE;
                    pend_nxt    = '0;
                    // A newer, deeper flush arriving in the release cycle is folded in.
                    if (req_v && !blk_new && (fs > pend)) eff_f = fs;
                end else if (req_v && (fs > pend)) begin
                    pend_nxt = fs;
                end
            end
            default: begin
                state_nxt = F_IDLE;
                pend_nxt  = '0;
            end
        endcase
        flush_act = accept || release_now;
    end

    // Stall merge: deepest unmasked requesting stage sets the stall/bubble boundary.
    always_comb begin
        s_any      = 1'b0;
        s_max      = 0;
        stall_int  = '0;
        bubble_int = '0;
        flush_int  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (stall_req[i] &&
                !(flush_act && (int'(SRC_STAGE[i*TAG_W +: TAG_W]) < int'(eff_f)))) begin
                if (!s_any || (int'(SRC_STAGE[i*TAG_W +: TAG_W]) > s_max))
                    s_max = int'(SRC_STAGE[i*TAG_W +: TAG_W]);
                s_any = 1'b1;
            end
        end
        for (int k = 0; k < NSTAGE; k++) begin
            stall_int[k]  = s_any && (k <= s_max);
            bubble_int[k] = s_any && (k == s_max + 1);
            flush_int[k]  = flush_act && (k < int'(eff_f));
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    always_comb begin
        stall      = cpu_rst_n ? stall_int  : '0;
        bubble     = cpu_rst_n ? bubble_int : '0;
        flush      = cpu_rst_n ? flush_int  : '0;
        flush_busy = (state == F_WAIT);
    end

    // FSM state and latched pending flush stage.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state <= F_IDLE;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
        end
    end

    // Watchdog: count consecutive stalled cycles, trip a sticky error at WDOG_CYC.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wd_cnt   <= '0;
            wdog_err <= 1'b0;
        end else if (WDOG_CYC == 0) begin
            wd_cnt   <= '0;
            wdog_err <= 1'b0;
        end else if (|stall_int) begin
            if (wd_cnt == WD_LAST) wdog_err <= 1'b1;
            else                   wd_cnt   <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    // Per-source stalled-cycle counters; masked requests still count.
    for (genvar g = 0; g < NSRC; g++) begin : g_cnt
        stall_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (cpu_clk),
            .rst_n (cpu_rst_n),
            .clr   (cnt_clr),
            .inc   (stall_req[g]),
            .cnt   (stall_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (NSTAGE=5, NSRC=3, CNT_W=3, WDOG_CYC=8).
module tb_pipe_hazard_ctrl;

    logic       cpu_clk;
    logic       cpu_rst_n;
    logic [2:0] stall_req;
    logic       flush_req;
    logic [2:0] flush_stg;
    logic       cnt_clr;
    logic [4:0] stall, bubble, flush;
    logic       flush_busy;
    logic [8:0] stall_cnt;
    logic       wdog_err;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(
        .NSTAGE(5), .NSRC(3), .SRC_STAGE(9'b011_001_000), .CNT_W(3), .WDOG_CYC(8)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .stall_req(stall_req),
        .flush_req(flush_req), .flush_stg(flush_stg), .cnt_clr(cnt_clr),
        .stall(stall), .bubble(bubble), .flush(flush), .flush_busy(flush_busy),
        .stall_cnt(stall_cnt), .wdog_err(wdog_err)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic apply_reset();
        cpu_rst_n = 1'b0;
        stall_req = '0; flush_req = 1'b0; flush_stg = '0; cnt_clr = 1'b0;
        repeat (2) @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        cpu_rst_n = 1'b0;
        stall_req = 3'b111; flush_req = 1'b1; flush_stg = 3'd2; cnt_clr = 1'b0;
        repeat (3) @(posedge cpu_clk);
        @(negedge cpu_clk);
        n_checks++; if (stall !== 5'b0)      begin n_errors++; $display("FAIL reset_stall: got %b want %b", stall, 5'b0); end
        n_checks++; if (bubble !== 5'b0)     begin n_errors++; $display("FAIL reset_bubble: got %b want %b", bubble, 5'b0); end
        n_checks++; if (flush !== 5'b0)      begin n_errors++; $display("FAIL reset_flush: got %b want %b", flush, 5'b0); end
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", flush_busy); end
        n_checks++; if (stall_cnt !== 9'b0)  begin n_errors++; $display("FAIL reset_cnt: got %h want 0", stall_cnt); end
        n_checks++; if (wdog_err !== 1'b0)   begin n_errors++; $display("FAIL reset_wdog: got %b want 0", wdog_err); end
    endtask

    task automatic test_single_stall();
        apply_reset();
        stall_req = 3'b010;
        @(negedge cpu_clk);
        n_checks++; if (stall !== 5'b00011)  begin n_errors++; $display("FAIL id_stall: got %b want %b", stall, 5'b00011); end
        n_checks++; if (bubble !== 5'b00100) begin n_errors++; $display("FAIL id_bubble: got %b want %b", bubble, 5'b00100); end
        step();
        stall_req = 3'b110;
        @(negedge cpu_clk);
        n_checks++; if (stall !== 5'b01111)  begin n_errors++; $display("FAIL mem_stall: got %b want %b", stall, 5'b01111); end
        n_checks++; if (bubble !== 5'b10000) begin n_errors++; $display("FAIL mem_bubble: got %b want %b", bubble, 5'b10000); end
        n_checks++; if (flush !== 5'b00000)  begin n_errors++; $display("FAIL mem_flush: got %b want %b", flush, 5'b0); end
        step();
        stall_req = 3'b001;
        @(negedge cpu_clk);
        n_checks++; if (stall !== 5'b00001)  begin n_errors++; $display("FAIL if_stall: got %b want %b", stall, 5'b00001); end
        n_checks++; if (bubble !== 5'b00010) begin n_errors++; $display("FAIL if_bubble: got %b want %b", bubble, 5'b00010); end
    endtask

    task automatic test_unblocked_flush();
        apply_reset();
        stall_req = 3'b001; flush_req = 1'b1; flush_stg = 3'd1;
        @(negedge cpu_clk);
        n_checks++; if (flush !== 5'b00001) begin n_errors++; $display("FAIL ub_flush: got %b want %b", flush, 5'b00001); end
        n_checks++; if (stall !== 5'b00000) begin n_errors++; $display("FAIL ub_stall_masked: got %b want %b", stall, 5'b0); end
        n_checks++; if (bubble !== 5'b00000) begin n_errors++; $display("FAIL ub_bubble_masked: got %b want %b", bubble, 5'b0); end
        step();
        flush_req = 1'b0; stall_req = 3'b000;
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL ub_busy: got %b want 0", flush_busy); end
    endtask

    task automatic test_flush_edges();
        apply_reset();
        // stage 0 flush kills nothing and never goes pending
        stall_req = 3'b100; flush_req = 1'b1; flush_stg = 3'd0;
        @(negedge cpu_clk);
        n_checks++; if (flush !== 5'b00000) begin n_errors++; $display("FAIL stg0_flush: got %b want %b", flush, 5'b0); end
        n_checks++; if (stall !== 5'b01111) begin n_errors++; $display("FAIL stg0_stall: got %b want %b", stall, 5'b01111); end
        step();
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL stg0_busy: got %b want 0", flush_busy); end
        // WB flush is not blocked by MEM stall; MEM request masked
        stall_req = 3'b100; flush_req = 1'b1; flush_stg = 3'd4;
        @(negedge cpu_clk);
        n_checks++; if (flush !== 5'b01111) begin n_errors++; $display("FAIL wb_flush: got %b want %b", flush, 5'b01111); end
        n_checks++; if (stall !== 5'b00000) begin n_errors++; $display("FAIL wb_stall_masked: got %b want %b", stall, 5'b0); end
        step();
        // out-of-range stage clamps to WB
        stall_req = 3'b000; flush_req = 1'b1; flush_stg = 3'd7;
        @(negedge cpu_clk);
        n_checks++; if (flush !== 5'b01111) begin n_errors++; $display("FAIL clamp_flush: got %b want %b", flush, 5'b01111); end
        step();
        flush_req = 1'b0;
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL clamp_busy: got %b want 0", flush_busy); end
    endtask

    task automatic test_deferred_flush();
        apply_reset();
        stall_req = 3'b100; flush_req = 1'b1; flush_stg = 3'd2;
        @(negedge cpu_clk);
        n_checks++; if (flush !== 5'b00000) begin n_errors++; $display("FAIL def_c0_flush: got %b want %b", flush, 5'b0); end
        n_checks++; if (stall !== 5'b01111) begin n_errors++; $display("FAIL def_c0_stall: got %b want %b", stall, 5'b01111); end
        step();
        flush_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge cpu_clk);
            n_checks++; if (flush_busy !== 1'b1) begin n_errors++; $display("FAIL def_busy_c%0d: got %b want 1", c, flush_busy); end
            n_checks++; if (flush !== 5'b00000) begin n_errors++; $display("FAIL def_flush_c%0d: got %b want %b", c, flush, 5'b0); end
            step();
        end
        stall_req = 3'b000;
        @(negedge cpu_clk);
        n_checks++; if (flush_busy !== 1'b1) begin n_errors++; $display("FAIL def_busy_c3: got %b want 1", flush_busy); end
        n_checks++; if (flush !== 5'b00011) begin n_errors++; $display("FAIL def_release: got %b want %b", flush, 5'b00011); end
        step();
        @(negedge cpu_clk);
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL def_busy_after: got %b want 0", flush_busy); end
        n_checks++; if (flush !== 5'b00000) begin n_errors++; $display("FAIL def_flush_after: got %b want %b", flush, 5'b0); end
    endtask

    task automatic test_wait_merge();
        apply_reset();
        stall_req = 3'b100; flush_req = 1'b1; flush_stg = 3'd1;
        step();
        flush_stg = 3'd2;
        @(negedge cpu_clk);
        n_checks++; if (flush_busy !== 1'b1) begin n_errors++; $display("FAIL wm_busy: got %b want 1", flush_busy); end
        n_checks++; if (stall !== 5'b01111) begin n_errors++; $display("FAIL wm_stall: got %b want %b", stall, 5'b01111); end
        step();
        flush_stg = 3'd1;
        step();
        flush_req = 1'b0; stall_req = 3'b000;
        @(negedge cpu_clk);
        n_checks++; if (flush !== 5'b00011) begin n_errors++; $display("FAIL wm_release: got %b want %b", flush, 5'b00011); end
        step();
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL wm_busy_after: got %b want 0", flush_busy); end
    endtask

    task automatic test_release_merge();
        apply_reset();
        stall_req = 3'b100; flush_req = 1'b1; flush_stg = 3'd1;
        step();
        stall_req = 3'b000; flush_req = 1'b1; flush_stg = 3'd3;
        @(negedge cpu_clk);
        n_checks++; if (flush !== 5'b00111) begin n_errors++; $display("FAIL rm_flush: got %b want %b", flush, 5'b00111); end
        step();
        flush_req = 1'b0;
        @(negedge cpu_clk);
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL rm_busy: got %b want 0", flush_busy); end
        n_checks++; if (flush !== 5'b00000) begin n_errors++; $display("FAIL rm_flush_after: got %b want %b", flush, 5'b0); end
    endtask

    task automatic test_reset_mid_flush();
        apply_reset();
        stall_req = 3'b100; flush_req = 1'b1; flush_stg = 3'd2;
        step();
        flush_req = 1'b0;
        n_checks++; if (flush_busy !== 1'b1) begin n_errors++; $display("FAIL rmf_busy_pre: got %b want 1", flush_busy); end
        cpu_rst_n = 1'b0;
        #1;
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL rmf_busy_async: got %b want 0", flush_busy); end
        n_checks++; if (stall_cnt !== 9'b0) begin n_errors++; $display("FAIL rmf_cnt_async: got %h want 0", stall_cnt); end
        stall_req = 3'b000;
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        step();
        @(negedge cpu_clk);
        n_checks++; if (flush !== 5'b00000) begin n_errors++; $display("FAIL rmf_dropped: got %b want %b", flush, 5'b0); end
        n_checks++; if (flush_busy !== 1'b0) begin n_errors++; $display("FAIL rmf_busy_post: got %b want 0", flush_busy); end
    endtask

    task automatic test_counters_wdog();
        apply_reset();
        stall_req = 3'b100;
        repeat (5) step();
        n_checks++; if (stall_cnt[8:6] !== 3'd5) begin n_errors++; $display("FAIL cnt_mid: got %0d want 5", stall_cnt[8:6]); end
        repeat (2) step();
        n_checks++; if (wdog_err !== 1'b0) begin n_errors++; $display("FAIL wdog_7cyc: got %b want 0", wdog_err); end
        step();
        n_checks++; if (wdog_err !== 1'b1) begin n_errors++; $display("FAIL wdog_8cyc: got %b want 1", wdog_err); end
        repeat (2) step();
        n_checks++; if (stall_cnt[8:6] !== 3'd7) begin n_errors++; $display("FAIL cnt_sat: got %0d want 7", stall_cnt[8:6]); end
        n_checks++; if (stall_cnt[5:0] !== 6'd0) begin n_errors++; $display("FAIL cnt_others: got %h want 0", stall_cnt[5:0]); end
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        n_checks++; if (stall_cnt !== 9'b0) begin n_errors++; $display("FAIL cnt_clr_prio: got %h want 0", stall_cnt); end
        n_checks++; if (wdog_err !== 1'b1) begin n_errors++; $display("FAIL wdog_sticky: got %b want 1", wdog_err); end
        step();
        n_checks++; if (stall_cnt[8:6] !== 3'd1) begin n_errors++; $display("FAIL cnt_after_clr: got %0d want 1", stall_cnt[8:6]); end
        stall_req = 3'b000;
    endtask

    task automatic test_wdog_gap();
        apply_reset();
        stall_req = 3'b010;
        repeat (7) step();
        stall_req = 3'b000;
        step();
        stall_req = 3'b001;
        repeat (7) step();
        n_checks++; if (wdog_err !== 1'b0) begin n_errors++; $display("FAIL wdog_gap: got %b want 0", wdog_err); end
        n_checks++; if (stall_cnt !== {3'd0, 3'd7, 3'd7}) begin n_errors++; $display("FAIL gap_cnts: got %h want %h", stall_cnt, {3'd0, 3'd7, 3'd7}); end
        step();
        n_checks++; if (wdog_err !== 1'b1) begin n_errors++; $display("FAIL wdog_gap_trip: got %b want 1", wdog_err); end
        stall_req = 3'b000;
    endtask

    initial begin
        cpu_rst_n = 1'b0;
        stall_req = '0; flush_req = 1'b0; flush_stg = '0; cnt_clr = 1'b0;
        test_reset();
        test_single_stall();
        test_unblocked_flush();
        test_flush_edges();
        test_deferred_flush();
        test_wait_merge();
        test_release_merge();
        test_reset_mid_flush();
        test_counters_wdog();
        test_wdog_gap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
